regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file and shares it between two writers:
  - the in-order pipeline writeback, which has fixed priority and can never be refused;
  - a long-latency unit (divider / multi-cycle load) using a valid/ready handshake.
- Holds a per-register pending scoreboard for long-latency destinations and raises a pipeline stall on RAW/WAW hazards against them.
- Sits between the WB stage / long-latency unit and the register-file write port; the ID stage consumes its stall.

Parameters:
- REG_NUM, 32, number of architectural registers; register 0 is hardwired zero.
- ADDR_W, 5, register address width (log2 REG_NUM).
- DATA_W, 32, register data width.
- MAX_WAIT, 4, consecutive refused cycles on the long-latency port before the starvation stall is forced.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- wb_we  in  1  pipeline writeback enable.
- wb_waddr  in  ADDR_W  pipeline writeback address.
- wb_wdata  in  DATA_W  pipeline writeback data.
- lu_valid  in  1  long-latency result valid.
- lu_waddr  in  ADDR_W  long-latency destination.
- lu_wdata  in  DATA_W  long-latency result.
- lu_ready  out  1  long-latency result accepted this cycle.
- iss_valid  in  1  long-latency op issued this cycle.
- iss_waddr  in  ADDR_W  destination of the issued op.
- id_re1  in  1  ID read enable 1.
- id_raddr1  in  ADDR_W  ID read address 1.
- id_re2  in  1  ID read enable 2.
- id_raddr2  in  ADDR_W  ID read address 2.
- id_we  in  1  ID instruction writes a register.
- id_waddr  in  ADDR_W  ID destination address.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  ADDR_W  register-file write address.
- rf_wdata  out  DATA_W  register-file write data.
- stall_req  out  1  stall request to the pipeline controller.
- pending  out  REG_NUM  scoreboard bit vector, for debug and verification.

Behaviour:
- Reset: clk and rst are the only clock and reset. Reset is synchronous, active-high. On reset, pending=0 and wait_cnt=0. While rst=1: rf_we=0, lu_ready=0, stall_req=0.
- Write mux (combinational, zero latency; the register file's own read bypass covers same-cycle reads):
  - wb_we=1: rf_* = wb_*, lu_ready=0.
  - else lu_valid=1: rf_* = lu_*, lu_ready=1.
  - else rf_we=0, and rf_waddr/rf_wdata=0.
- Handshake: the long-latency unit holds lu_valid, lu_waddr and lu_wdata stable until lu_valid&&lu_ready. lu_ready never depends on stall_req.
- Starvation counter wait_cnt (width clog2(MAX_WAIT+1)):
  - lu_valid && !lu_ready: increment, saturating at MAX_WAIT.
  - any grant, or lu_valid=0: clear to 0.
  - starve = (wait_cnt==MAX_WAIT). starve forces stall_req so the pipeline drains a bubble into WB.
- Scoreboard, per register r, next-state rules:
  - Set when iss_valid && iss_waddr==r && r!=0 && !stall_req.
  - Clear when lu_valid && lu_ready && lu_waddr==r.
  - Set and clear on the same r in the same cycle: set wins.
  - pending[0] is always 0.
- Hazard terms (a source or destination is "busy" when pending[x]=1 and it is not being cleared this cycle):
  - raw = (id_re1 && busy(id_raddr1)) || (id_re2 && busy(id_raddr2)).
  - waw = id_we && busy(id_waddr).
  - iss_conf = iss_valid && pending[iss_waddr].
- A register cleared this cycle is not a hazard, because the register-file bypass delivers lu_wdata.
- stall_req = raw || waw || iss_conf || starve. This is combinational from state plus inputs, with no pipeline register.
- An iss_valid that arrives while stall_req=1 does not set pending. The issuing stage re-presents it.
- Writes to address 0 pass through to the register file, which ignores them. Address 0 never sets pending.

Decomposition:
- Defines.vh gains:
  - `LuMaxWait (4);
  - `Stall / `NoStall encodings;
  - reuse of existing `RegAddrBus, `RegBus, `RegNum, `WriteEnable, `RstEnable.
- One sub-module, wb_scoreboard: owns the pending vector, its set/clear logic and the busy() lookups.
- Top level keeps the write mux, starvation counter and stall OR.

Test Plan:
- Reset, then iss_valid with iss_waddr=5 -> pending=0x20 next cycle; rf_we=0; stall_req=0.
- pending[5]=1, id_re1=1, id_raddr1=5 -> stall_req=1. Then lu_valid=1, lu_waddr=5, lu_wdata=0xDEADBEEF, wb_we=0 -> same cycle: lu_ready=1, rf_we=1, rf_wdata=0xDEADBEEF, stall_req=0; pending=0 next cycle.
- wb_we=1 with waddr=3, data=0x11, and lu_valid=1 with lu_waddr=7 held -> rf_waddr=3, lu_ready=0 for 4 cycles. Cycle 5: stall_req=1 (starve). Drop wb_we -> lu_ready=1, rf_waddr=7, wait_cnt=0 next cycle.
- Same-cycle iss_valid iss_waddr=9 and lu grant lu_waddr=9 (pending[9]=1 beforehand) -> iss_conf stalls and the issue is refused. Separately, with pending[9]=0, a same-cycle issue to 9 and grant to 4 -> pending[9]=1, pending[4]=0.
- iss_waddr=0 and id_raddr1=0 reads -> pending stays 0, stall_req=0.
- Assert rst while pending=0xFFFFFFFE and wait_cnt=3 -> next cycle pending=0, wait_cnt=0, stall_req=0, rf_we=0.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
// Default geometry, starvation limit and stall/write-enable encodings.
package regfile_wb_arbiter_pkg;

   localparam int   DEF_REG_NUM   = 32;
   localparam int   DEF_ADDR_W    = 5;
   localparam int   DEF_DATA_W    = 32;
   localparam int   LU_MAX_WAIT   = 4;

   localparam logic STALL         = 1'b1;
   localparam logic NO_STALL      = 1'b0;
   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;

endpackage

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Pending-write scoreboard for long-latency destinations, with busy lookups
// that treat a register being retired this cycle as already available.
module wb_scoreboard
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int REG_NUM = DEF_REG_NUM,
   parameter int ADDR_W  = DEF_ADDR_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               set_en,
   input  logic [ADDR_W-1:0]  set_addr,
   input  logic               clr_en,
   input  logic [ADDR_W-1:0]  clr_addr,
   input  logic [ADDR_W-1:0]  rd1_addr,
   input  logic [ADDR_W-1:0]  rd2_addr,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [ADDR_W-1:0]  iss_addr,
   output logic               busy1,
   output logic               busy2,
   output logic               busy_w,
   output logic               iss_pend,
   output logic [REG_NUM-1:0] pending
);

   logic [REG_NUM-1:0] pending_q;
   logic [REG_NUM-1:0] pending_d;
   logic [REG_NUM-1:0] clr_vec;
   logic [REG_NUM-1:0] busy_vec;

   // The register-file bypass forwards lu_wdata, so a clearing entry is not busy.
   generate
      for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_busy
         assign clr_vec[gi]  = clr_en && (clr_addr == ADDR_W'(gi));
         assign busy_vec[gi] = pending_q[gi] && !clr_vec[gi];
      end
   endgenerate

   always_comb begin
      pending_d = pending_q & ~clr_vec;
      if (set_en) begin
         pending_d[set_addr] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign busy1    = busy_vec[rd1_addr];
   assign busy2    = busy_vec[rd2_addr];
   assign busy_w   = busy_vec[wr_addr];
   assign iss_pend = pending_q[iss_addr];
   assign pending  = pending_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between pipeline writeback (fixed
// priority) and a long-latency unit, and raises hazard/starvation stalls.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int REG_NUM  = DEF_REG_NUM,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int MAX_WAIT = LU_MAX_WAIT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wb_we,
   input  logic [ADDR_W-1:0]  wb_waddr,
   input  logic [DATA_W-1:0]  wb_wdata,
   input  logic               lu_valid,
   input  logic [ADDR_W-1:0]  lu_waddr,
   input  logic [DATA_W-1:0]  lu_wdata,
   output logic               lu_ready,
   input  logic               iss_valid,
   input  logic [ADDR_W-1:0]  iss_waddr,
   input  logic               id_re1,
   input  logic [ADDR_W-1:0]  id_raddr1,
   input  logic               id_re2,
   input  logic [ADDR_W-1:0]  id_raddr2,
   input  logic               id_we,
   input  logic [ADDR_W-1:0]  id_waddr,
   output logic               rf_we,
   output logic [ADDR_W-1:0]  rf_waddr,
   output logic [DATA_W-1:0]  rf_wdata,
   output logic               stall_req,
   output logic [REG_NUM-1:0] pending
);

   localparam int              CNT_W   = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

   logic [CNT_W-1:0] wait_cnt_q;
   logic [CNT_W-1:0] wait_cnt_d;
   logic             starve;
   logic             busy1, busy2, busy_w, iss_pend;
   logic             raw, waw, iss_conf;

   always_comb begin
      rf_we    = WRITE_DISABLE;
      rf_waddr = '0;
      rf_wdata = '0;
      lu_ready = 1'b0;
      if (!rst) begin
         if (wb_we) begin
            rf_we    = WRITE_ENABLE;
            rf_waddr = wb_waddr;
            rf_wdata = wb_wdata;
         end else if (lu_valid) begin
            rf_we    = WRITE_ENABLE;
            rf_waddr = lu_waddr;
            rf_wdata = lu_wdata;
            lu_ready = 1'b1;
         end
      end
   end

   always_comb begin
      wait_cnt_d = '0;
      if (lu_valid && !lu_ready) begin
         wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign starve = (wait_cnt_q == CNT_MAX);

   wb_scoreboard #(
      .REG_NUM (REG_NUM),
      .ADDR_W  (ADDR_W)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .set_en   (iss_valid && !stall_req),
      .set_addr (iss_waddr),
      .clr_en   (lu_valid && lu_ready),
      .clr_addr (lu_waddr),
      .rd1_addr (id_raddr1),
      .rd2_addr (id_raddr2),
      .wr_addr  (id_waddr),
      .iss_addr (iss_waddr),
      .busy1    (busy1),
      .busy2    (busy2),
      .busy_w   (busy_w),
      .iss_pend (iss_pend),
      .pending  (pending)
   );

   // Issue conflict uses the raw pending bit: a same-cycle retire does not free the slot.
   assign raw      = (id_re1 && busy1) || (id_re2 && busy2);
   assign waw      = id_we && busy_w;
   assign iss_conf = iss_valid && iss_pend;

   assign stall_req = rst ? NO_STALL
                          : ((raw || waw || iss_conf || starve) ? STALL : NO_STALL);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed-vector bench: the driver queues expected outputs per cycle and an
// independent negedge monitor pops and compares them.
module tb_regfile_wb_arbiter;

   localparam bit [5:0] M_WE = 6'd1;
   localparam bit [5:0] M_WA = 6'd2;
   localparam bit [5:0] M_WD = 6'd4;
   localparam bit [5:0] M_LR = 6'd8;
   localparam bit [5:0] M_ST = 6'd16;
   localparam bit [5:0] M_PD = 6'd32;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_we;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic        lu_valid;
   logic [4:0]  lu_waddr;
   logic [31:0] lu_wdata;
   logic        lu_ready;
   logic        iss_valid;
   logic [4:0]  iss_waddr;
   logic        id_re1;
   logic [4:0]  id_raddr1;
   logic        id_re2;
   logic [4:0]  id_raddr2;
   logic        id_we;
   logic [4:0]  id_waddr;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        stall_req;
   logic [31:0] pending;

   typedef struct {
      string       name;
      bit [5:0]    mask;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        lr;
      logic        st;
      logic [31:0] pd;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   regfile_wb_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .wb_we     (wb_we),
      .wb_waddr  (wb_waddr),
      .wb_wdata  (wb_wdata),
      .lu_valid  (lu_valid),
      .lu_waddr  (lu_waddr),
      .lu_wdata  (lu_wdata),
      .lu_ready  (lu_ready),
      .iss_valid (iss_valid),
      .iss_waddr (iss_waddr),
      .id_re1    (id_re1),
      .id_raddr1 (id_raddr1),
      .id_re2    (id_re2),
      .id_raddr2 (id_raddr2),
      .id_we     (id_we),
      .id_waddr  (id_waddr),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .stall_req (stall_req),
      .pending   (pending)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string nm, input string fld, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s %s got 0x%08h want 0x%08h", nm, fld, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         if (mon_e.mask[0]) cmp(mon_e.name, "rf_we",     32'(rf_we),     32'(mon_e.we));
         if (mon_e.mask[1]) cmp(mon_e.name, "rf_waddr",  32'(rf_waddr),  32'(mon_e.wa));
         if (mon_e.mask[2]) cmp(mon_e.name, "rf_wdata",  rf_wdata,       mon_e.wd);
         if (mon_e.mask[3]) cmp(mon_e.name, "lu_ready",  32'(lu_ready),  32'(mon_e.lr));
         if (mon_e.mask[4]) cmp(mon_e.name, "stall_req", 32'(stall_req), 32'(mon_e.st));
         if (mon_e.mask[5]) cmp(mon_e.name, "pending",   pending,        mon_e.pd);
         $display("txn %-16s rf_we=%0b rf_waddr=%0d rf_wdata=0x%08h lu_ready=%0b stall=%0b pending=0x%08h",
                  mon_e.name, rf_we, rf_waddr, rf_wdata, lu_ready, stall_req, pending);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_cycle(input string nm, input bit [5:0] m, input logic we,
                               input logic [4:0] wa, input logic [31:0] wd,
                               input logic lr, input logic st, input logic [31:0] pd);
      exp_t e;
      e.name = nm; e.mask = m; e.we = we; e.wa = wa; e.wd = wd;
      e.lr = lr; e.st = st; e.pd = pd;
      exp_q.push_back(e);
      tick();
   endtask

   task automatic idle_inputs();
      rst = 1'b0;
      wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
      lu_valid = 1'b0; lu_waddr = '0; lu_wdata = '0;
      iss_valid = 1'b0; iss_waddr = '0;
      id_re1 = 1'b0; id_raddr1 = '0;
      id_re2 = 1'b0; id_raddr2 = '0;
      id_we = 1'b0; id_waddr = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      rst = 1'b1;
      wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h11;
      lu_valid = 1'b1; lu_waddr = 5'd7;
      iss_valid = 1'b1; iss_waddr = 5'd5;
      tick();
      expect_cycle("rst_hold", M_WE|M_LR|M_ST|M_PD, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);

      idle_inputs();
      expect_cycle("idle", 6'h3F, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);

      iss_valid = 1'b1; iss_waddr = 5'd5;
      expect_cycle("iss5", M_WE|M_ST|M_PD, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
      idle_inputs();
      expect_cycle("pend5", M_WE|M_ST|M_PD, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'h20);

      id_re1 = 1'b1; id_raddr1 = 5'd5;
      expect_cycle("raw1", M_ST|M_PD, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'h20);
      idle_inputs(); id_re2 = 1'b1; id_raddr2 = 5'd5;
      expect_cycle("raw2", M_ST, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'd0);
      idle_inputs(); id_we = 1'b1; id_waddr = 5'd5;
      expect_cycle("waw", M_ST, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'd0);
      idle_inputs(); id_re1 = 1'b1; id_raddr1 = 5'd6; id_we = 1'b1; id_waddr = 5'd6;
      expect_cycle("nohaz", M_ST, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);

      idle_inputs(); id_re1 = 1'b1; id_raddr1 = 5'd5;
      lu_valid = 1'b1; lu_waddr = 5'd5; lu_wdata = 32'hDEADBEEF;
      expect_cycle("lu_grant", M_WE|M_WA|M_WD|M_LR|M_ST, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 32'd0);
      idle_inputs();
      expect_cycle("clr5", M_PD|M_ST, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);

      wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h11;
      lu_valid = 1'b1; lu_waddr = 5'd7; lu_wdata = 32'h77;
      for (int i = 0; i < 4; i++)
         expect_cycle("wb_prio", M_WE|M_WA|M_WD|M_LR|M_ST, 1'b1, 5'd3, 32'h11, 1'b0, 1'b0, 32'd0);
      expect_cycle("starve", M_WA|M_LR|M_ST, 1'b1, 5'd3, 32'h11, 1'b0, 1'b1, 32'd0);
      wb_we = 1'b0;
      expect_cycle("starve_grant", M_WE|M_WA|M_WD|M_LR|M_ST, 1'b1, 5'd7, 32'h77, 1'b1, 1'b1, 32'd0);
      idle_inputs();
      expect_cycle("starve_clr", M_WE|M_LR|M_ST, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);

      iss_valid = 1'b1; iss_waddr = 5'd9;
      expect_cycle("iss9", M_ST|M_PD, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
      lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'h99;
      expect_cycle("iss_conf", M_WA|M_LR|M_ST|M_PD, 1'b1, 5'd9, 32'd0, 1'b1, 1'b1, 32'h200);
      idle_inputs();
      expect_cycle("iss_refused", M_ST|M_PD, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
      iss_valid = 1'b1; iss_waddr = 5'd9;
      lu_valid = 1'b1; lu_waddr = 5'd4; lu_wdata = 32'h44;
      expect_cycle("iss_other_grant", M_WA|M_LR|M_ST, 1'b1, 5'd4, 32'd0, 1'b1, 1'b0, 32'd0);
      idle_inputs();
      expect_cycle("pend9", M_PD, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'h200);
      lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'h99;
      expect_cycle("clr9", M_LR|M_ST, 1'b1, 5'd9, 32'd0, 1'b1, 1'b0, 32'd0);
      idle_inputs();
      expect_cycle("clr9_done", M_PD, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);

      iss_valid = 1'b1; iss_waddr = 5'd0;
      id_re1 = 1'b1; id_raddr1 = 5'd0; id_we = 1'b1; id_waddr = 5'd0;
      wb_we = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'h5;
      expect_cycle("zero", M_WE|M_WA|M_WD|M_ST|M_PD, 1'b1, 5'd0, 32'h5, 1'b0, 1'b0, 32'd0);
      idle_inputs();
      expect_cycle("zero_pend", M_ST|M_PD, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);

      for (int r = 1; r < 32; r++) begin
         iss_valid = 1'b1; iss_waddr = 5'(r);
         expect_cycle("fill", M_ST, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
      end
      idle_inputs();
      expect_cycle("full", M_PD, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'hFFFFFFFE);

      wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h11;
      lu_valid = 1'b1; lu_waddr = 5'd7; lu_wdata = 32'h77;
      tick(); tick(); tick();
      rst = 1'b1;
      expect_cycle("rst_mid", M_WE|M_LR|M_ST, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++)
         expect_cycle("post_rst", M_WE|M_ST|M_PD, 1'b1, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
      expect_cycle("post_rst_starve", M_ST, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'd0);
      idle_inputs();
      tick();
      tick();

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain queue left %0d want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
